// File: rtl/muldiv_pkg.sv
// Shared types and constants for the mul/div execute-stage sequencer.
// Contents: state encoding, iteration counter width, zero-result constant.
package muldiv_pkg;

    localparam int unsigned CNT_W = 6;
    localparam int unsigned RES_W = 64;

    localparam logic [RES_W-1:0] ZERO_RES = '0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MUL_RUN = 2'd1,
        ST_DIV_RUN = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

endpackage

// File: rtl/muldiv_ctrl.sv
// Execute-stage sequencer for the multi-cycle multiplier and iterative divider.
// Accepts one mul/div request from E, latches operands, stalls the pipeline
// while the unit runs, then holds the 64-bit HI/LO result until E advances.
//
// Ports:
//   clk, rst           clock (rising edge), asynchronous active-low reset
//   req_*_i, src_*_i   request qualifiers and forwarded operands from E
//   advance_i, flush_i pipeline advance / flush
//   div_ready_i/res_i  divider handshake and {remainder, quotient}
//   mul_res_i          multiplier {hi, lo}
//   op_*_o             latched operands to the arithmetic units
//   div_start_o        held high during DIV_RUN (combinational)
//   div_cancel_o       one-cycle divider abort pulse
//   stall_o            stall request to the hazard unit (combinational)
//   res_valid_o, res_hi_o, res_lo_o  held result
//   err_o              one-cycle divider watchdog pulse
//
// Build option: define MULDIV_DIV0_FASTPATH_EN to complete divide-by-zero in
// one cycle (hi = dividend, lo = all ones) without starting the divider.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int unsigned MUL_LAT     = 2,
    parameter int unsigned DIV_LAT_MAX = 40
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    input  logic        req_is_mul_i,
    input  logic        req_signed_i,
    input  logic [31:0] src_a_i,
    input  logic [31:0] src_b_i,
    input  logic        advance_i,
    input  logic        flush_i,
    input  logic        div_ready_i,
    input  logic [63:0] div_res_i,
    input  logic [63:0] mul_res_i,
    output logic [31:0] op_a_o,
    output logic [31:0] op_b_o,
    output logic        op_signed_o,
    output logic        div_start_o,
    output logic        div_cancel_o,
    output logic        stall_o,
    output logic        res_valid_o,
    output logic [31:0] res_hi_o,
    output logic [31:0] res_lo_o,
    output logic        err_o
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       op_a_q, op_a_d;
    logic [31:0]       op_b_q, op_b_d;
    logic              op_signed_q, op_signed_d;
    logic [RES_W-1:0]  res_q, res_d;
    logic              res_valid_q, res_valid_d;
    logic              div_cancel_q, div_cancel_d;
    logic              err_q, err_d;

    // State, counter, operand and result registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            op_signed_q  <= 1'b0;
            res_q        <= '0;
            res_valid_q  <= 1'b0;
            div_cancel_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            op_signed_q  <= op_signed_d;
            res_q        <= res_d;
            res_valid_q  <= res_valid_d;
            div_cancel_q <= div_cancel_d;
            err_q        <= err_d;
        end
    end

    // Next-state, datapath updates and decoded stall/start
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        op_signed_d  = op_signed_q;
        res_d        = res_q;
        res_valid_d  = res_valid_q;
        div_cancel_d = 1'b0;
        err_d        = 1'b0;
        stall_o      = 1'b0;
        div_start_o  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                res_valid_d = 1'b0;
                if (req_valid_i && !flush_i) begin
                    stall_o     = 1'b1;
                    op_a_d      = src_a_i;
                    op_b_d      = src_b_i;
                    op_signed_d = req_signed_i;
                    cnt_d       = '0;
                    if (req_is_mul_i) begin
                        state_d = ST_MUL_RUN;
                    end else begin
`ifdef MULDIV_DIV0_FASTPATH_EN
                        if (src_b_i == 32'h0) begin
                            res_d       = {src_a_i, 32'hFFFF_FFFF};
                            res_valid_d = 1'b1;
                            state_d     = ST_DONE;
                        end else begin
                            state_d = ST_DIV_RUN;
                        end
`else
                        state_d = ST_DIV_RUN;
`endif
                    end
                end
            end
            ST_MUL_RUN: begin
                stall_o = 1'b1;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(MUL_LAT - 1)) begin
                    res_d       = mul_res_i;
                    res_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end
            end
            ST_DIV_RUN: begin
                stall_o     = 1'b1;
                div_start_o = 1'b1;
                cnt_d       = cnt_q + CNT_W'(1);
                if (div_ready_i) begin
                    res_d       = div_res_i;
                    res_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end else if (cnt_q == CNT_W'(DIV_LAT_MAX - 1)) begin
                    // Watchdog: abort the divider and return a zero result
                    res_d        = ZERO_RES;
                    res_valid_d  = 1'b1;
                    err_d        = 1'b1;
                    div_cancel_d = 1'b1;
                    state_d      = ST_DONE;
                end
            end
            ST_DONE: begin
                // Hold result without restarting until E advances
                if (advance_i) begin
                    res_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Flush overrides everything, including a same-cycle divider result
        if (flush_i) begin
            state_d      = ST_IDLE;
            res_valid_d  = 1'b0;
            err_d        = 1'b0;
            div_cancel_d = (state_q == ST_DIV_RUN);
            res_d        = res_q;
        end
    end

    assign op_a_o       = op_a_q;
    assign op_b_o       = op_b_q;
    assign op_signed_o  = op_signed_q;
    assign div_cancel_o = div_cancel_q;
    assign res_valid_o  = res_valid_q;
    assign res_hi_o     = res_q[63:32];
    assign res_lo_o     = res_q[31:0];
    assign err_o        = err_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: randomized mul/div transactions with a
// behavioural arithmetic model, a result scoreboard and a monitor process.
module tb_muldiv_ctrl;

    localparam int unsigned MUL_LAT     = 2;
    localparam int unsigned DIV_LAT_MAX = 40;

    logic        clk;
    logic        rst;
    logic        req_valid_i;
    logic        req_is_mul_i;
    logic        req_signed_i;
    logic [31:0] src_a_i;
    logic [31:0] src_b_i;
    logic        advance_i;
    logic        flush_i;
    logic        div_ready_i;
    logic [63:0] div_res_i;
    logic [63:0] mul_res_i;
    logic [31:0] op_a_o;
    logic [31:0] op_b_o;
    logic        op_signed_o;
    logic        div_start_o;
    logic        div_cancel_o;
    logic        stall_o;
    logic        res_valid_o;
    logic [31:0] res_hi_o;
    logic [31:0] res_lo_o;
    logic        err_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [63:0] res;
        logic        err;
    } exp_t;

    exp_t sb_q[$];

    muldiv_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT_MAX(DIV_LAT_MAX)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_i  (req_valid_i),
        .req_is_mul_i (req_is_mul_i),
        .req_signed_i (req_signed_i),
        .src_a_i      (src_a_i),
        .src_b_i      (src_b_i),
        .advance_i    (advance_i),
        .flush_i      (flush_i),
        .div_ready_i  (div_ready_i),
        .div_res_i    (div_res_i),
        .mul_res_i    (mul_res_i),
        .op_a_o       (op_a_o),
        .op_b_o       (op_b_o),
        .op_signed_o  (op_signed_o),
        .div_start_o  (div_start_o),
        .div_cancel_o (div_cancel_o),
        .stall_o      (stall_o),
        .res_valid_o  (res_valid_o),
        .res_hi_o     (res_hi_o),
        .res_lo_o     (res_lo_o),
        .err_o        (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Arithmetic reference: HI/LO for mul, {remainder, quotient} for div
    function automatic logic [63:0] model(input bit is_mul, input bit sgn,
                                          input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        int              qa, qb;
        if (is_mul) begin
            if (sgn) begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                return 64'(sa * sb);
            end
            ua = 64'(a);
            ub = 64'(b);
            return 64'(ua * ub);
        end
        if (sgn) begin
            qa = $signed(a);
            qb = $signed(b);
            return {32'(qa % qb), 32'(qa / qb)};
        end
        return {a % b, a / b};
    endfunction

    // Monitor: compare every newly presented result against the scoreboard
    logic prev_valid = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (rst && res_valid_o && !prev_valid) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_result", 64'd1, 64'd0);
            end else begin
                e = sb_q.pop_front();
                chk("mon_res_hi", 64'(res_hi_o), 64'(e.res[63:32]));
                chk("mon_res_lo", 64'(res_lo_o), 64'(e.res[31:0]));
                chk("mon_err", 64'(err_o), 64'(e.err));
            end
        end
        prev_valid = res_valid_o;
    end

    // One transaction: div_lat = cycle of DIV_RUN in which the divider reports
    // ready (0 = never), flush_at = DIV/MUL run cycle carrying a flush (0 = none)
    task automatic run_op(input bit is_mul, input bit sgn, input logic [31:0] a,
                          input logic [31:0] b, input int div_lat, input int hold,
                          input int flush_at);
        logic [63:0] exp_res;
        bit          wdog;
        int          stalls;
        int          starts;
        bit          done;
        exp_t        e;
        wdog    = !is_mul && div_lat == 0 && flush_at == 0;
        exp_res = wdog ? 64'h0 : model(is_mul, sgn, a, b);
        if (flush_at == 0) begin
            e.res = exp_res;
            e.err = wdog;
            sb_q.push_back(e);
        end

        req_valid_i  = 1'b1;
        req_is_mul_i = is_mul;
        req_signed_i = sgn;
        src_a_i      = a;
        src_b_i      = b;
        @(negedge clk);
        stalls = int'(stall_o);
        starts = int'(div_start_o);
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        chk("op_latch_a", 64'(op_a_o), 64'(a));
        chk("op_latch_b", 64'(op_b_o), 64'(b));

        done = 1'b0;
        for (int k = 1; k <= 100 && !done; k++) begin
            src_a_i     = $urandom;
            src_b_i     = $urandom;
            mul_res_i   = (is_mul && k == int'(MUL_LAT)) ? exp_res : {$urandom, $urandom};
            div_ready_i = !is_mul && (k == div_lat || k == flush_at);
            div_res_i   = (!is_mul && k == div_lat) ? exp_res : {$urandom, $urandom};
            flush_i     = (k == flush_at);
            @(negedge clk);
            stalls += int'(stall_o);
            starts += int'(div_start_o);
            @(posedge clk);
            #1;
            flush_i     = 1'b0;
            div_ready_i = 1'b0;
            if (k == flush_at) begin
                chk("flush_cancel", 64'(div_cancel_o), 64'(!is_mul));
                chk("flush_valid", 64'(res_valid_o), 64'd0);
                chk("flush_stall", 64'(stall_o), 64'd0);
                @(posedge clk);
                #1;
                chk("flush_cancel_pulse", 64'(div_cancel_o), 64'd0);
                return;
            end
            if (res_valid_o) done = 1'b1;
        end
        if (!done) begin
            chk("result_timeout", 64'd1, 64'd0);
            return;
        end

        chk("stall_cycles", 64'(stalls),
            is_mul ? 64'(1 + MUL_LAT) : (wdog ? 64'(1 + DIV_LAT_MAX) : 64'(1 + div_lat)));
        chk("start_cycles", 64'(starts),
            is_mul ? 64'd0 : (wdog ? 64'(DIV_LAT_MAX) : 64'(div_lat)));
        chk("done_err", 64'(err_o), 64'(wdog));
        chk("done_cancel", 64'(div_cancel_o), 64'(wdog));

        advance_i = 1'b0;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            chk("hold_valid", 64'(res_valid_o), 64'd1);
            chk("hold_res", {res_hi_o, res_lo_o}, exp_res);
            chk("hold_ctl", {61'd0, stall_o, div_start_o, err_o}, 64'd0);
        end
        advance_i = 1'b1;
        @(posedge clk);
        #1;
        advance_i = 1'b0;
        chk("adv_idle_valid", 64'(res_valid_o), 64'd0);
        chk("adv_idle_stall", 64'(stall_o), 64'd0);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        rst          = 1'b0;
        req_valid_i  = 1'b0;
        req_is_mul_i = 1'b0;
        req_signed_i = 1'b0;
        src_a_i      = '0;
        src_b_i      = '0;
        advance_i    = 1'b0;
        flush_i      = 1'b0;
        div_ready_i  = 1'b0;
        div_res_i    = '0;
        mul_res_i    = '0;

        repeat (2) @(negedge clk);
        chk("reset_outputs",
            {op_a_o, 21'd0, op_signed_o, div_start_o, div_cancel_o, stall_o,
             res_valid_o, err_o, res_hi_o[3:0] | res_lo_o[3:0]}, 64'd0);
        chk("reset_res", {res_hi_o, res_lo_o}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Signed 100 / -7 with ready on the 36th DIV_RUN cycle
        run_op(1'b0, 1'b1, 32'd100, 32'hFFFF_FFF9, 36, 0, 0);
        // Divide held in DONE for 5 cycles
        run_op(1'b0, 1'b0, 32'd1000, 32'd33, 12, 5, 0);
        // Unsigned 0xFFFFFFFF * 2
        run_op(1'b1, 1'b0, 32'hFFFF_FFFF, 32'd2, 0, 1, 0);
        // Flush on DIV_RUN cycle 10, same cycle as a divider ready
        run_op(1'b0, 1'b1, 32'd77, 32'd5, 20, 0, 10);
        // Divider never ready: watchdog
        run_op(1'b0, 1'b0, 32'd9, 32'd3, 0, 2, 0);
        // Flush during a multiply
        run_op(1'b1, 1'b1, 32'd3, 32'd4, 0, 0, 1);

        for (int i = 0; i < 14; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (rb == 32'h0) rb = 32'd1;
            if (ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) rb = 32'd1;
            run_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra, rb,
                   $urandom_range(1, 39), $urandom_range(0, 4), 0);
        end

`ifdef MULDIV_DIV0_FASTPATH_EN
        begin
            exp_t e;
            e.res = {32'd5, 32'hFFFF_FFFF};
            e.err = 1'b0;
            sb_q.push_back(e);
            req_valid_i  = 1'b1;
            req_is_mul_i = 1'b0;
            req_signed_i = 1'b0;
            src_a_i      = 32'd5;
            src_b_i      = 32'd0;
            @(negedge clk);
            chk("div0_start_accept", 64'(div_start_o), 64'd0);
            @(posedge clk);
            #1;
            req_valid_i = 1'b0;
            chk("div0_valid", 64'(res_valid_o), 64'd1);
            chk("div0_start_done", 64'(div_start_o), 64'd0);
            advance_i = 1'b1;
            @(posedge clk);
            #1;
            advance_i = 1'b0;
            chk("div0_idle", 64'(res_valid_o), 64'd0);
        end
`endif

        repeat (2) @(posedge clk);
        chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
